lc4_alu_sequencer: RTL
======================

# lc4_alu_sequencer

Multi-cycle front end for the LC4 ALU. It accepts one instruction at a time over a valid/ready handshake and produces registered results:
- Single-cycle ops are evaluated by an instance of `lc4_alu`.
- DIV and MOD run on an internal 16-step iterative restoring divider, replacing the combinational divider on that path.
- It sits between decode/register read and writeback in the multi-cycle pipeline.

## Interface
Parameters:
- `DIV_STEPS`, 16: divider iterations; equals the datapath width and must not be changed.

Ports (clock and reset first):
- `clk` — in, 1: single clock; all state updates on the rising edge.
- `rst` — in, 1: **synchronous, active-low** reset (asserted when 0).
- `i_valid` — in, 1: request present.
- `o_ready` — out, 1: request accepted on a rising edge where `i_valid & o_ready`.
- `i_insn` — in, 16: LC4 instruction.
- `i_pc` — in, 16: PC of the instruction.
- `i_r1data` — in, 16: rs operand.
- `i_r2data` — in, 16: rt operand.
- `o_valid` — out, 1: result available.
- `i_ready` — in, 1: consumer takes the result when `o_valid & i_ready`.
- `o_result` — out, 16: registered result.
- `o_busy` — out, 1: high while the divider is iterating.

## Operation
- **Long ops:**
  - DIV: opcode `0001` with `insn[5:3]=011`.
  - MOD: opcode `1010` with `insn[5:4]=11`.
  - All other opcodes are short ops.
- **State machine:** IDLE, CALC, DONE.
  - IDLE + accept of a short op → DONE. `o_result` takes the `lc4_alu` output computed from the captured inputs.
  - IDLE + accept of a long op with `i_r2data != 0` → CALC. Capture dividend and divisor, clear the remainder, set the step counter to 15.
  - IDLE + accept of a long op with `i_r2data == 0` → DONE with `o_result = 0`.
  - CALC: one restoring step per cycle, unsigned.
    - r' = {rem, dividend msb}.
    - If r' ≥ divisor: rem = r' − divisor and the quotient bit is 1; otherwise rem = r' and the quotient bit is 0.
    - Shift the quotient bit into the dividend register.
    - Decrement the counter. When the counter reaches 0, load `o_result` with the quotient (DIV) or remainder (MOD) and go to DONE.
  - DONE: `o_valid = 1`. `o_result` holds stable until `i_ready`.
    - On `i_ready`, go to IDLE, or accept a new request in the same cycle (see `o_ready` below).
- **Output equations:**
  - `o_ready = (state==IDLE) | (state==DONE & i_ready)`
  - `o_valid = (state==DONE)`
  - `o_busy = (state==CALC)`
- Inputs are ignored whenever `o_ready = 0`. Operands are captured at accept; later changes on the inputs have no effect.
- All divider arithmetic is 16-bit unsigned, using a 17-bit compare/subtract.

## Timing
- **Reset** (`rst = 0` at an edge) → state IDLE, `o_valid = 0`, `o_result = 0`, `o_busy = 0`, counter 0, all data registers 0. `o_ready` = 1 once `rst` is released.
- **Reset mid-CALC or mid-DONE** aborts the operation. No result is emitted.
- **Short op:** accept at edge E0; `o_valid` is high from E0 until handshake.
- **Long op:** accept at E0; CALC occupies E0..E16 (16 cycles); `o_valid` rises after E16. Latency is 17 cycles.
- **Divide by zero:** latency 1 cycle, result 0 for both DIV and MOD.
- **Back-to-back:** a handshake on DONE and an accept in the same cycle are legal. Throughput is 1 per cycle for short ops and 1 per 17 cycles for long ops.
- **Backpressure:** with `i_ready = 0`, the block stays in DONE indefinitely with `o_result` unchanged.

## Structure
- **Package `lc4_seq_pkg`** holds:
  - the state enum (IDLE, CALC, DONE);
  - `OP_ARITH = 4'b0001`, `OP_SHIFT = 4'b1010`;
  - `SUB_DIV = 3'b011`, `SUB_MOD = 2'b11`;
  - `DIV_STEPS = 16`.
- **Sub-module `lc4_div_step`:** combinational single restoring step.
  - Inputs: rem, dividend, divisor.
  - Outputs: next rem, next dividend.
  - Instantiated once and iterated by the FSM.
- **Existing `lc4_alu`** is instantiated unchanged for short ops.

## Test plan
- **ADD:** `i_insn = 0x1001`, r1 = 5, r2 = 7, `i_ready = 1` → `o_valid` high the cycle after accept, `o_result = 12`, `o_ready` stays high.
- **DIV:** `0x1019`, r1 = 100, r2 = 7 → `o_busy` for 16 cycles, `o_ready = 0` throughout, `o_result = 14` at cycle 17.
- **MOD:**
  - `0xA031`, r1 = 100, r2 = 7 → 2.
  - r1 = 0xFFFF, r2 = 1 → 0.
  - DIV with the same operands → 0xFFFF.
- **Divide by zero:** DIV and MOD with r2 = 0 → `o_result = 0` one cycle after accept, `o_busy` never asserts.
- **Backpressure:** hold `i_ready = 0` for 5 cycles in DONE → `o_result` stable and `o_ready = 0`. Raise `i_ready` with a new ADD presented → the handshake and the accept happen on the same edge.
- **Reset mid-DIV:** drive `rst = 0` on the 8th CALC cycle → next cycle IDLE, `o_valid = 0`, `o_result = 0`, `o_busy = 0`. A following DIV 100/7 → 14.

Source files
------------

// File: rtl/lc4_seq_pkg.sv
// Shared types and opcode constants for the multi-cycle LC4 ALU front end.
package lc4_seq_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_e;

   localparam logic [3:0]  OP_ARITH  = 4'b0001;
   localparam logic [3:0]  OP_SHIFT  = 4'b1010;
   localparam logic [2:0]  SUB_DIV   = 3'b011;
   localparam logic [1:0]  SUB_MOD   = 2'b11;
   localparam int unsigned DIV_STEPS = 16;

   // DIV and MOD take the iterative divider path; everything else is single-cycle.
   function automatic logic is_long_op(input logic [15:0] insn);
      return ((insn[15:12] == OP_ARITH) && (insn[5:3] == SUB_DIV)) ||
             ((insn[15:12] == OP_SHIFT) && (insn[5:4] == SUB_MOD));
   endfunction

endpackage

// File: rtl/lc4_alu.sv
// Combinational LC4 ALU: arithmetic, logic, shifts, compares and address/branch targets.
module lc4_alu (
   input  logic [15:0] i_insn,
   input  logic [15:0] i_pc,
   input  logic [15:0] i_r1data,
   input  logic [15:0] i_r2data,
   output logic [15:0] o_result
);

   logic [15:0]        pc_inc;
   logic signed [16:0] cmp_a;
   logic signed [16:0] cmp_b;
   logic [15:0]        cmp_res;

   assign pc_inc = i_pc + 16'd1;

   // Widening to 17 bits lets signed and unsigned compares share one signed comparator.
   always_comb begin
      cmp_a = {i_r1data[15], i_r1data};
      cmp_b = {i_r2data[15], i_r2data};
      case (i_insn[8:7])
         2'b00: begin
            cmp_a = {i_r1data[15], i_r1data};
            cmp_b = {i_r2data[15], i_r2data};
         end
         2'b01: begin
            cmp_a = {1'b0, i_r1data};
            cmp_b = {1'b0, i_r2data};
         end
         2'b10: begin
            cmp_a = {i_r1data[15], i_r1data};
            cmp_b = {{10{i_insn[6]}}, i_insn[6:0]};
         end
         default: begin
            cmp_a = {1'b0, i_r1data};
            cmp_b = {10'b0, i_insn[6:0]};
         end
      endcase
      if (cmp_a < cmp_b)       cmp_res = 16'hFFFF;
      else if (cmp_a == cmp_b) cmp_res = 16'h0000;
      else                     cmp_res = 16'h0001;
   end

   always_comb begin
      o_result = '0;
      case (i_insn[15:12])
         4'b0000: o_result = pc_inc + {{7{i_insn[8]}}, i_insn[8:0]};
         4'b0001: begin
            if (i_insn[5]) o_result = i_r1data + {{11{i_insn[4]}}, i_insn[4:0]};
            else begin
               case (i_insn[4:3])
                  2'b00:   o_result = i_r1data + i_r2data;
                  2'b01:   o_result = i_r1data * i_r2data;
                  2'b10:   o_result = i_r1data - i_r2data;
                  default: o_result = (i_r2data == '0) ? '0 : i_r1data / i_r2data;
               endcase
            end
         end
         4'b0010: o_result = cmp_res;
         4'b0100: o_result = i_insn[11] ? {i_pc[15], i_insn[10:0], 4'b0000} : i_r1data;
         4'b0101: begin
            if (i_insn[5]) o_result = i_r1data & {{11{i_insn[4]}}, i_insn[4:0]};
            else begin
               case (i_insn[4:3])
                  2'b00:   o_result = i_r1data & i_r2data;
                  2'b01:   o_result = ~i_r1data;
                  2'b10:   o_result = i_r1data | i_r2data;
                  default: o_result = i_r1data ^ i_r2data;
               endcase
            end
         end
         4'b0110, 4'b0111: o_result = i_r1data + {{10{i_insn[5]}}, i_insn[5:0]};
         4'b1000: o_result = i_r1data;
         4'b1001: o_result = {{7{i_insn[8]}}, i_insn[8:0]};
         4'b1010: begin
            case (i_insn[5:4])
               2'b00:   o_result = i_r1data << i_insn[3:0];
               2'b01:   o_result = $signed(i_r1data) >>> i_insn[3:0];
               2'b10:   o_result = i_r1data >> i_insn[3:0];
               default: o_result = (i_r2data == '0) ? '0 : i_r1data % i_r2data;
            endcase
         end
         4'b1100: o_result = i_insn[11] ? pc_inc + {{5{i_insn[10]}}, i_insn[10:0]} : i_r1data;
         4'b1101: o_result = {i_insn[7:0], i_r1data[7:0]};
         4'b1111: o_result = {8'h80, i_insn[7:0]};
         default: o_result = '0;
      endcase
   end

endmodule

// File: rtl/lc4_div_step.sv
// One unsigned restoring-division step: shift in the dividend MSB, trial-subtract the divisor.
module lc4_div_step (
   input  logic [15:0] rem_i,
   input  logic [15:0] dvd_i,
   input  logic [15:0] dvs_i,
   output logic [15:0] rem_o,
   output logic [15:0] dvd_o
);

   logic [16:0] r_sh;
   logic [16:0] diff;
   logic        ge;

   assign r_sh = {rem_i, dvd_i[15]};
   assign diff = r_sh - {1'b0, dvs_i};
   // rem < divisor always holds, so the borrow bit alone decides r' >= divisor.
   assign ge    = ~diff[16];
   assign rem_o = ge ? diff[15:0] : r_sh[15:0];
   assign dvd_o = {dvd_i[14:0], ge};

endmodule

// File: rtl/lc4_alu_sequencer.sv
// Multi-cycle LC4 ALU front end: single-cycle ops through lc4_alu, DIV/MOD on an iterative divider.
module lc4_alu_sequencer #(
   parameter int unsigned DIV_STEPS = lc4_seq_pkg::DIV_STEPS
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [15:0] i_insn,
   input  logic [15:0] i_pc,
   input  logic [15:0] i_r1data,
   input  logic [15:0] i_r2data,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [15:0] o_result,
   output logic        o_busy
);

   import lc4_seq_pkg::*;

   localparam int unsigned CW = $clog2(DIV_STEPS);

   state_e         state_q;
   logic [CW-1:0]  cnt_q;
   logic [15:0]    rem_q;
   logic [15:0]    dvd_q;
   logic [15:0]    dvs_q;
   logic [15:0]    result_q;
   logic           mod_q;
   logic [15:0]    rem_d;
   logic [15:0]    dvd_d;
   logic [15:0]    alu_res;
   logic           accept;

   lc4_alu u_alu (
      .i_insn   (i_insn),
      .i_pc     (i_pc),
      .i_r1data (i_r1data),
      .i_r2data (i_r2data),
      .o_result (alu_res)
   );

   lc4_div_step u_div_step (
      .rem_i (rem_q),
      .dvd_i (dvd_q),
      .dvs_i (dvs_q),
      .rem_o (rem_d),
      .dvd_o (dvd_d)
   );

   assign o_ready  = (state_q == IDLE) || ((state_q == DONE) && i_ready);
   assign o_valid  = (state_q == DONE);
   assign o_busy   = (state_q == CALC);
   assign o_result = result_q;
   assign accept   = i_valid && o_ready;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         rem_q    <= '0;
         dvd_q    <= '0;
         dvs_q    <= '0;
         result_q <= '0;
         mod_q    <= 1'b0;
      end else if (accept) begin
         mod_q <= (i_insn[15:12] == OP_SHIFT);
         if (!is_long_op(i_insn)) begin
            result_q <= alu_res;
            state_q  <= DONE;
         end else if (i_r2data == '0) begin
            result_q <= '0;
            state_q  <= DONE;
         end else begin
            dvd_q   <= i_r1data;
            dvs_q   <= i_r2data;
            rem_q   <= '0;
            cnt_q   <= CW'(DIV_STEPS - 1);
            state_q <= CALC;
         end
      end else begin
         case (state_q)
            CALC: begin
               rem_q <= rem_d;
               dvd_q <= dvd_d;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == '0) begin
                  cnt_q    <= '0;
                  result_q <= mod_q ? rem_d : dvd_d;
                  state_q  <= DONE;
               end
            end
            DONE: if (i_ready) state_q <= IDLE;
            default: ;
         endcase
      end
   end

endmodule
